// File: rtl/conv_pkg.sv
// Shared constants and types for the convolution-unit dispatch queue.
package conv_pkg;

    localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
    localparam logic [2:0] F3_CLR      = 3'b000;
    localparam logic [2:0] F3_MAC      = 3'b001;
    localparam logic [2:0] F3_RD       = 3'b010;

    // One queued instruction bundle, 143 bits.
    typedef struct packed {
        logic [31:0] opcode;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ra_op;
        logic [31:0] rb_op;
    } conv_entry_t;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_WAIT = 2'd1,
        D_GAP  = 2'd2
    } disp_state_t;

    function automatic logic is_custom0(input logic [31:0] opcode);
        return opcode[6:0] == OPC_CUSTOM0;
    endfunction

endpackage

// File: rtl/conv_dispatch_queue_if.sv
// Issue, convolution-unit and writeback signals of the dispatch queue.
interface conv_dispatch_queue_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
);
    logic             issue_valid_i;
    logic [31:0]      issue_opcode_i;
    logic [31:0]      issue_pc_i;
    logic             issue_invalid_i;
    logic [4:0]       issue_rd_idx_i;
    logic [4:0]       issue_ra_idx_i;
    logic [4:0]       issue_rb_idx_i;
    logic [31:0]      issue_ra_operand_i;
    logic [31:0]      issue_rb_operand_i;
    logic             flush_i;
    logic             stall_o;
    logic             conv_valid_o;
    logic [31:0]      conv_opcode_o;
    logic [31:0]      conv_pc_o;
    logic [31:0]      conv_ra_operand_o;
    logic [31:0]      conv_rb_operand_o;
    logic [4:0]       conv_rd_idx_o;
    logic [4:0]       conv_ra_idx_o;
    logic [4:0]       conv_rb_idx_o;
    logic             conv_invalid_o;
    logic             conv_busy_i;
    logic             conv_valid_i;
    logic [31:0]      conv_writeback_i;
    logic             wb_valid_o;
    logic [4:0]       wb_rd_idx_o;
    logic [31:0]      wb_value_o;
    logic [CNT_W-1:0] level_o;

    modport slave (
        input  issue_valid_i, issue_opcode_i, issue_pc_i, issue_invalid_i,
               issue_rd_idx_i, issue_ra_idx_i, issue_rb_idx_i,
               issue_ra_operand_i, issue_rb_operand_i, flush_i,
               conv_busy_i, conv_valid_i, conv_writeback_i,
        output stall_o, conv_valid_o, conv_opcode_o, conv_pc_o,
               conv_ra_operand_o, conv_rb_operand_o, conv_rd_idx_o,
               conv_ra_idx_o, conv_rb_idx_o, conv_invalid_o,
               wb_valid_o, wb_rd_idx_o, wb_value_o, level_o
    );

    modport master (
        output issue_valid_i, issue_opcode_i, issue_pc_i, issue_invalid_i,
               issue_rd_idx_i, issue_ra_idx_i, issue_rb_idx_i,
               issue_ra_operand_i, issue_rb_operand_i, flush_i,
               conv_busy_i, conv_valid_i, conv_writeback_i,
        input  stall_o, conv_valid_o, conv_opcode_o, conv_pc_o,
               conv_ra_operand_o, conv_rb_operand_o, conv_rd_idx_o,
               conv_ra_idx_o, conv_rb_idx_o, conv_invalid_o,
               wb_valid_o, wb_rd_idx_o, wb_value_o, level_o
    );

endinterface

// File: rtl/conv_entry_fifo.sv
// Synchronous FIFO of conv_entry_t with flush; head reads as zero when empty.
module conv_entry_fifo
    import conv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  conv_entry_t      entry_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output conv_entry_t      head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);

    conv_entry_t      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_count == CNT_W'(DEPTH));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign head_o  = empty_o ? '0 : r_mem[r_rd_ptr];

    // Full blocks a push even when a pop frees a slot in the same cycle.
    assign w_push = push_i && !full_o && !flush_i;
    assign w_pop  = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= entry_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/conv_dispatch_queue.sv
// Queues custom-0 instructions and feeds them one at a time to the convolution
// unit, tagging each completion with its destination register.
//
// state  | meaning
// D_IDLE | unit free; dispatch head entry when queue non-empty
// D_WAIT | one op outstanding; waiting for unit completion pulse
// D_GAP  | one cycle for the unit to settle back to idle
module conv_dispatch_queue
    import conv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    conv_dispatch_queue_if.slave   bus
);
    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    disp_state_t      r_state;
    disp_state_t      w_next;
    logic [4:0]       r_out_rd;
    conv_entry_t      w_entry;
    conv_entry_t      w_head;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic             w_dispatch;
    logic             w_wb_valid;

    // Reset asserts immediately and releases two clocks after rst_ni rises.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_entry = '{
        opcode: bus.issue_opcode_i,
        pc:     bus.issue_pc_i,
        rd:     bus.issue_rd_idx_i,
        ra:     bus.issue_ra_idx_i,
        rb:     bus.issue_rb_idx_i,
        ra_op:  bus.issue_ra_operand_i,
        rb_op:  bus.issue_rb_operand_i
    };

    assign w_push = bus.issue_valid_i && is_custom0(bus.issue_opcode_i) &&
                    !bus.issue_invalid_i && !w_full && !bus.flush_i;

    conv_entry_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (w_rst_n),
        .push_i  (w_push),
        .entry_i (w_entry),
        .pop_i   (w_pop),
        .flush_i (bus.flush_i),
        .head_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state  <= D_IDLE;
            r_out_rd <= '0;
        end else begin
            r_state <= w_next;
            if (w_pop) begin
                r_out_rd <= w_head.rd;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_dispatch = 1'b0;
        w_pop      = 1'b0;
        w_wb_valid = 1'b0;
        unique case (r_state)
            D_IDLE: begin
                if (!w_empty && !bus.flush_i && !bus.conv_busy_i) begin
                    w_dispatch = 1'b1;
                    w_pop      = 1'b1;
                    w_next     = D_WAIT;
                end
            end
            D_WAIT: begin
                if (bus.conv_valid_i) begin
                    w_wb_valid = 1'b1;
                    w_next     = D_GAP;
                end
            end
            D_GAP:   w_next = D_IDLE;
            default: w_next = D_IDLE;
        endcase
    end

    assign bus.stall_o           = w_full;
    assign bus.level_o           = w_count;
    assign bus.conv_valid_o      = w_dispatch;
    assign bus.conv_opcode_o     = w_head.opcode;
    assign bus.conv_pc_o         = w_head.pc;
    assign bus.conv_rd_idx_o     = w_head.rd;
    assign bus.conv_ra_idx_o     = w_head.ra;
    assign bus.conv_rb_idx_o     = w_head.rb;
    assign bus.conv_ra_operand_o = w_head.ra_op;
    assign bus.conv_rb_operand_o = w_head.rb_op;
    assign bus.conv_invalid_o    = 1'b0;
    assign bus.wb_valid_o        = w_wb_valid;
    assign bus.wb_rd_idx_o       = r_out_rd;
    assign bus.wb_value_o        = bus.conv_writeback_i;

endmodule

// File: tb/tb_conv_dispatch_queue.sv
// Directed bench for conv_dispatch_queue with a behavioural convolution unit
// and dispatch/writeback scoreboards.
module tb_conv_dispatch_queue;
    import conv_pkg::*;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] v;
    } exp_t;

    typedef enum int {U_IDLE, U_START, U_EXEC, U_STOP} unit_state_t;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_disp = -1;
    exp_t disp_q[$];
    exp_t wb_q[$];

    conv_dispatch_queue_if bus ();

    conv_dispatch_queue dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic real f32_to_real(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        for (int i = 0; i < e; i++) m = m * 2.0;
        for (int i = 0; i < -e; i++) m = m / 2.0;
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] real_to_f32(input real v);
        real    m;
        int     e;
        logic   s;
        longint fr;
        if (v == 0.0) return 32'h0;
        s = (v < 0.0);
        m = s ? -v : v;
        e = 127;
        while (m >= 2.0 && e < 254) begin m = m / 2.0; e++; end
        while (m < 1.0 && e > 1) begin m = m * 2.0; e--; end
        fr = longint'((m - 1.0) * 8388608.0);
        return {s, e[7:0], fr[22:0]};
    endfunction

    function automatic logic [31:0] mk_op(input logic [2:0] f3, input logic [4:0] rd);
        return {17'd0, f3, rd, OPC_CUSTOM0};
    endfunction

    // Behavioural convolution unit: START, EXECUTE, STOP, then a completion pulse.
    unit_state_t u_st = U_IDLE;
    logic        u_busy = 1'b0;
    logic        u_valid = 1'b0;
    logic [31:0] u_wb = 32'h0;
    logic [2:0]  u_f3 = 3'd0;
    logic [31:0] u_a = 32'h0;
    logic [31:0] u_b = 32'h0;
    real         u_acc = 0.0;
    logic        force_busy = 1'b0;

    assign bus.conv_busy_i      = u_busy | force_busy;
    assign bus.conv_valid_i     = u_valid;
    assign bus.conv_writeback_i = u_wb;

    always @(posedge clk_i) begin
        u_valid <= 1'b0;
        case (u_st)
            U_IDLE: if (bus.conv_valid_o) begin
                u_f3   <= bus.conv_opcode_o[14:12];
                u_a    <= bus.conv_ra_operand_o;
                u_b    <= bus.conv_rb_operand_o;
                u_busy <= 1'b1;
                u_st   <= U_START;
            end
            U_START: u_st <= U_EXEC;
            U_EXEC:  u_st <= U_STOP;
            U_STOP: begin
                case (u_f3)
                    F3_CLR: begin u_acc <= 0.0; u_wb <= 32'h0; end
                    F3_MAC: begin
                        u_acc <= u_acc + f32_to_real(u_a) * f32_to_real(u_b);
                        u_wb  <= real_to_f32(u_acc + f32_to_real(u_a) * f32_to_real(u_b));
                    end
                    default: u_wb <= real_to_f32(u_acc);
                endcase
                u_valid <= 1'b1;
                u_busy  <= 1'b0;
                u_st    <= U_IDLE;
            end
            default: u_st <= U_IDLE;
        endcase
    end

    // Dispatch scoreboard: order, rd tag and minimum spacing.
    always @(negedge clk_i) begin
        exp_t e;
        if (bus.conv_valid_o) begin
            chk("disp_expected", disp_q.size() != 0, 1);
            chk("disp_invalid_tie", bus.conv_invalid_o, 0);
            if (last_disp >= 0) chk("disp_spacing", (cyc - last_disp) >= 6, 1);
            last_disp = cyc;
            if (disp_q.size() != 0) begin
                e = disp_q.pop_front();
                chk("disp_rd", bus.conv_rd_idx_o, e.rd);
                wb_q.push_back(e);
            end
        end
    end

    // Writeback scoreboard: tag and value of each completion.
    always @(negedge clk_i) begin
        exp_t e;
        if (bus.wb_valid_o) begin
            chk("wb_expected", wb_q.size() != 0, 1);
            if (wb_q.size() != 0) begin
                e = wb_q.pop_front();
                chk("wb_rd", bus.wb_rd_idx_o, e.rd);
                chk("wb_value", bus.wb_value_o, e.v);
            end
        end
    end

    task automatic drive(input logic [31:0] opc, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b, input logic inv);
        bus.issue_valid_i      = 1'b1;
        bus.issue_opcode_i     = opc;
        bus.issue_pc_i         = 32'h1000 + {27'd0, rd};
        bus.issue_invalid_i    = inv;
        bus.issue_rd_idx_i     = rd;
        bus.issue_ra_idx_i     = rd + 5'd1;
        bus.issue_rb_idx_i     = rd + 5'd2;
        bus.issue_ra_operand_i = a;
        bus.issue_rb_operand_i = b;
    endtask

    // Presents a bundle until the queue is not stalled, then records the expected result.
    task automatic issue(input logic [31:0] opc, input logic [4:0] rd, input logic [31:0] a,
                         input logic [31:0] b, input logic inv, input logic [31:0] expv);
        logic st;
        logic fl;
        bit   done = 0;
        exp_t e;
        drive(opc, rd, a, b, inv);
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk_i);
            st = bus.stall_o;
            fl = bus.flush_i;
            @(posedge clk_i);
            #1;
            if (!st) begin
                done = 1;
                if (opc[6:0] == OPC_CUSTOM0 && !inv && !fl) begin
                    e.rd = rd;
                    e.v  = expv;
                    disp_q.push_back(e);
                end
            end
        end
        chk("issue_timeout", done, 1);
        bus.issue_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((disp_q.size() != 0 || wb_q.size() != 0) && n < 300) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        chk("drain_timeout", n < 300, 1);
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        bus.issue_valid_i = 1'b0;
        drive(32'h0, 5'd0, 32'h0, 32'h0, 1'b0);
        bus.issue_valid_i = 1'b0;
        bus.flush_i       = 1'b0;

        // Reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_stall", bus.stall_o, 0);
        chk("rst_level", bus.level_o, 0);
        chk("rst_conv_valid", bus.conv_valid_o, 0);
        chk("rst_wb_valid", bus.wb_valid_o, 0);
        chk("rst_wb_rd", bus.wb_rd_idx_o, 0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;

        // Single MAC: dispatch exactly one cycle after the enqueue
        chk("t1_idle_before", bus.conv_valid_o, 0);
        issue(mk_op(F3_MAC, 5'd7), 5'd7, 32'h3F800000, 32'h40000000, 1'b0, 32'h40000000);
        @(negedge clk_i);
        chk("t1_disp_latency", bus.conv_valid_o, 1);
        chk("t1_disp_ra_op", bus.conv_ra_operand_o, 32'h3F800000);
        chk("t1_disp_rb_op", bus.conv_rb_operand_o, 32'h40000000);
        @(posedge clk_i);
        #1;
        wait_drain();
        chk("t1_level_after", bus.level_o, 0);
        chk("t1_head_zero", bus.conv_opcode_o, 0);

        // Back-to-back issues with the unit held busy
        force_busy = 1'b1;
        for (int k = 1; k <= 4; k++)
            issue(mk_op(F3_CLR, 5'(k)), 5'(k), 32'h0, 32'h0, 1'b0, 32'h0);
        chk("t2_stall_full", bus.stall_o, 1);
        chk("t2_level_full", bus.level_o, 4);
        drive(mk_op(F3_CLR, 5'd5), 5'd5, 32'h0, 32'h0, 1'b0);
        repeat (3) begin
            @(negedge clk_i);
            chk("t2_hold_level", bus.level_o, 4);
            chk("t2_hold_stall", bus.stall_o, 1);
        end
        @(posedge clk_i);
        #1 force_busy = 1'b0;
        issue(mk_op(F3_CLR, 5'd5), 5'd5, 32'h0, 32'h0, 1'b0, 32'h0);
        issue(mk_op(F3_CLR, 5'd6), 5'd6, 32'h0, 32'h0, 1'b0, 32'h0);
        wait_drain();

        // Ignored bundles: non-custom opcode and flagged-invalid custom-0
        issue(32'h00000033, 5'd3, 32'h0, 32'h0, 1'b0, 32'h0);
        issue(mk_op(F3_MAC, 5'd4), 5'd4, 32'h0, 32'h0, 1'b1, 32'h0);
        repeat (4) begin
            @(negedge clk_i);
            chk("t3_level", bus.level_o, 0);
            chk("t3_no_disp", bus.conv_valid_o, 0);
        end
        @(posedge clk_i);
        #1;

        // Flush with three queued and one outstanding
        force_busy = 1'b1;
        for (int k = 11; k <= 14; k++)
            issue(mk_op(F3_CLR, 5'(k)), 5'(k), 32'h0, 32'h0, 1'b0, 32'h0);
        force_busy = 1'b0;
        @(posedge clk_i);
        #1;
        chk("t4_level_pre", bus.level_o, 3);
        bus.flush_i = 1'b1;
        drive(mk_op(F3_CLR, 5'd20), 5'd20, 32'h0, 32'h0, 1'b0);
        @(posedge clk_i);
        #1;
        bus.flush_i = 1'b0;
        bus.issue_valid_i = 1'b0;
        disp_q.delete();
        chk("t4_level_post", bus.level_o, 0);
        chk("t4_stall_post", bus.stall_o, 0);
        wait_drain();
        repeat (12) @(posedge clk_i);
        #1;
        chk("t4_level_end", bus.level_o, 0);

        // Reset while an op is outstanding with two queued
        force_busy = 1'b1;
        for (int k = 21; k <= 23; k++)
            issue(mk_op(F3_CLR, 5'(k)), 5'(k), 32'h0, 32'h0, 1'b0, 32'h0);
        force_busy = 1'b0;
        @(posedge clk_i);
        #1;
        chk("t5_level_pre", bus.level_o, 2);
        chk("t5_wb_rd_pre", bus.wb_rd_idx_o, 21);
        rst_ni = 1'b0;
        #1;
        chk("t5_rst_conv_valid", bus.conv_valid_o, 0);
        chk("t5_rst_wb_valid", bus.wb_valid_o, 0);
        chk("t5_rst_stall", bus.stall_o, 0);
        chk("t5_rst_level", bus.level_o, 0);
        chk("t5_rst_wb_rd", bus.wb_rd_idx_o, 0);
        chk("t5_rst_head_rd", bus.conv_rd_idx_o, 0);
        disp_q.delete();
        wb_q.delete();
        #2 rst_ni = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk_i);
            if (bus.conv_valid_i) begin
                seen++;
                chk("t5_late_wb", bus.wb_valid_o, 0);
            end
        end
        chk("t5_late_pulse_seen", seen, 1);
        @(posedge clk_i);
        #1;

        // Accumulate sequence: CLR, MAC(2,3), MAC(1,4), RD
        issue(mk_op(F3_CLR, 5'd1), 5'd1, 32'h0, 32'h0, 1'b0, 32'h0);
        issue(mk_op(F3_MAC, 5'd2), 5'd2, 32'h40000000, 32'h40400000, 1'b0, 32'h40C00000);
        issue(mk_op(F3_MAC, 5'd3), 5'd3, 32'h3F800000, 32'h40800000, 1'b0, 32'h41200000);
        issue(mk_op(F3_RD, 5'd9), 5'd9, 32'h0, 32'h0, 1'b0, 32'h41200000);
        wait_drain();
        chk("t6_final_rd", bus.wb_rd_idx_o, 9);
        chk("t6_level_end", bus.level_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
